// File: rtl/sal_sched_rr.sv
// rtl/sal_sched_rr.sv - multi-bank DDR2 command scheduler, class priority plus round-robin bank pick
// Optional four-activate window check enabled by defining SCHED_FAW_EN.
module sal_sched_rr #(
  parameter int BK_CNT = 4,
  parameter int T_RRD  = 2,
  parameter int T_CCD  = 2,
  parameter int T_WTR  = 3,
  parameter int T_RTW  = 4,
  parameter int T_FAW  = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [BK_CNT-1:0]         act_req,
  input  logic [BK_CNT-1:0]         rd_req,
  input  logic [BK_CNT-1:0]         wr_req,
  input  logic [BK_CNT-1:0]         pre_req,
  input  logic [BK_CNT-1:0]         ref_req,
  output logic [BK_CNT-1:0]         act_gnt,
  output logic [BK_CNT-1:0]         rd_gnt,
  output logic [BK_CNT-1:0]         wr_gnt,
  output logic [BK_CNT-1:0]         pre_gnt,
  output logic [BK_CNT-1:0]         ref_gnt,
  output logic                      cmd_valid,
  output logic [2:0]                cmd_type,
  output logic [$clog2(BK_CNT)-1:0] cmd_bank
);

  localparam int BW      = $clog2(BK_CNT);
  localparam int T_MAX_A = (T_RRD > T_CCD) ? T_RRD : T_CCD;
  localparam int T_MAX_B = (T_WTR > T_RTW) ? T_WTR : T_RTW;
  localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int TW      = $clog2(T_MAX + 1);

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;
  localparam logic [2:0] CMD_REF = 3'd5;

  logic [BW-1:0]     rr_ptr;
  logic [TW-1:0]     rrd_cnt;
  logic [TW-1:0]     ccd_cnt;
  logic [TW-1:0]     wtr_cnt;
  logic [TW-1:0]     rtw_cnt;
  logic              last_cas_wr;

  logic              rd_ok;
  logic              wr_ok;
  logic              act_ok;
  logic              faw_ok;
  logic [2:0]        sel_type;
  logic [BK_CNT-1:0] sel_vec;
  logic              found;
  logic [BW-1:0]     sel_bank;
  logic              grant;
  logic [BK_CNT-1:0] bank_oh;

  function automatic logic [TW-1:0] dec(input logic [TW-1:0] v);
    return (v == '0) ? v : v - TW'(1);
  endfunction

  assign rd_ok  = (|rd_req) && (ccd_cnt == '0) && (wtr_cnt == '0);
  assign wr_ok  = (|wr_req) && (ccd_cnt == '0) && (rtw_cnt == '0);
  assign act_ok = (|act_req) && (rrd_cnt == '0) && faw_ok;

  // Blocked classes fall through; when both CAS directions are open, stay in the last one.
  always_comb begin
    sel_type = CMD_NOP;
    sel_vec  = '0;
    if (|pre_req) begin
      sel_type = CMD_PRE;
      sel_vec  = pre_req;
    end else if (rd_ok && wr_ok) begin
      sel_type = last_cas_wr ? CMD_WR : CMD_RD;
      sel_vec  = last_cas_wr ? wr_req : rd_req;
    end else if (rd_ok) begin
      sel_type = CMD_RD;
      sel_vec  = rd_req;
    end else if (wr_ok) begin
      sel_type = CMD_WR;
      sel_vec  = wr_req;
    end else if (act_ok) begin
      sel_type = CMD_ACT;
      sel_vec  = act_req;
    end else if (|ref_req) begin
      sel_type = CMD_REF;
      sel_vec  = ref_req;
    end
  end

  always_comb begin
    logic [BW-1:0] idx;
    found    = 1'b0;
    sel_bank = '0;
    idx      = '0;
    for (int k = 0; k < BK_CNT; k++) begin
      idx = BW'((int'(rr_ptr) + k) % BK_CNT);
      if (!found && sel_vec[idx]) begin
        found    = 1'b1;
        sel_bank = idx;
      end
    end
  end

  assign grant   = found && !rst;
  assign bank_oh = {{(BK_CNT-1){1'b0}}, 1'b1} << sel_bank;

  always_comb begin
    act_gnt = '0;
    rd_gnt  = '0;
    wr_gnt  = '0;
    pre_gnt = '0;
    ref_gnt = '0;
    if (grant) begin
      case (sel_type)
        CMD_ACT: act_gnt = bank_oh;
        CMD_RD:  rd_gnt  = bank_oh;
        CMD_WR:  wr_gnt  = bank_oh;
        CMD_PRE: pre_gnt = bank_oh;
        CMD_REF: ref_gnt = bank_oh;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr      <= '0;
      rrd_cnt     <= '0;
      ccd_cnt     <= '0;
      wtr_cnt     <= '0;
      rtw_cnt     <= '0;
      last_cas_wr <= 1'b0;
      cmd_valid   <= 1'b0;
      cmd_type    <= CMD_NOP;
      cmd_bank    <= '0;
    end else begin
      rrd_cnt <= (grant && sel_type == CMD_ACT) ? TW'(T_RRD - 1) : dec(rrd_cnt);
      ccd_cnt <= (grant && (sel_type == CMD_RD || sel_type == CMD_WR)) ?
                 TW'(T_CCD - 1) : dec(ccd_cnt);
      rtw_cnt <= (grant && sel_type == CMD_RD) ? TW'(T_RTW - 1) : dec(rtw_cnt);
      wtr_cnt <= (grant && sel_type == CMD_WR) ? TW'(T_WTR - 1) : dec(wtr_cnt);
      if (grant && sel_type == CMD_RD) last_cas_wr <= 1'b0;
      if (grant && sel_type == CMD_WR) last_cas_wr <= 1'b1;
      if (grant) begin
        rr_ptr   <= (sel_bank == BW'(BK_CNT - 1)) ? '0 : sel_bank + BW'(1);
        cmd_bank <= sel_bank;
      end
      cmd_valid <= grant;
      cmd_type  <= grant ? sel_type : CMD_NOP;
    end
  end

`ifdef SCHED_FAW_EN
  localparam int FW = $clog2(T_FAW + 1);

  // Slot 3 holds the age of the fourth-most-recent ACT; ages saturate at T_FAW (expired).
  logic [FW-1:0] faw_age [4];

  function automatic logic [FW-1:0] age_inc(input logic [FW-1:0] a);
    return (a >= FW'(T_FAW)) ? FW'(T_FAW) : a + FW'(1);
  endfunction

  assign faw_ok = (faw_age[3] >= FW'(T_FAW - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) faw_age[i] <= FW'(T_FAW);
    end else if (grant && sel_type == CMD_ACT) begin
      faw_age[0] <= '0;
      for (int i = 1; i < 4; i++) faw_age[i] <= age_inc(faw_age[i-1]);
    end else begin
      for (int i = 0; i < 4; i++) faw_age[i] <= age_inc(faw_age[i]);
    end
  end
`else
  // Without the window check T_FAW has no effect on eligibility.
  assign faw_ok = 1'b1 | (T_FAW < 0);
`endif

endmodule
